// File: rtl/cam_cmd_master.sv
// cam_cmd_master: initiator for the CAM read/write/search ports.
// It takes one command at a time, pulses the matching CAM enable for one
// cycle and waits CAM_LAT cycles for read/search results. It then holds one
// response until it is consumed.
// Optional build macro CAM_CMD_STATS_EN adds saturating search hit/miss counters.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both 1. Valid never waits on ready. Payload stays stable while valid is
// high and ready is low. cmd_ready_o depends only on FSM state and reset, never
// on cmd_valid_i.
module cam_cmd_master #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32,
    parameter int CAM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [IDX_W-1:0]  cmd_index_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              cam_read_enable_o,
    output logic [IDX_W-1:0]  cam_read_index_o,
    output logic              cam_write_enable_o,
    output logic [IDX_W-1:0]  cam_write_index_o,
    output logic [DATA_W-1:0] cam_write_data_o,
    output logic              cam_search_enable_o,
    output logic [DATA_W-1:0] cam_search_data_o,
    input  logic              cam_read_valid_i,
    input  logic [DATA_W-1:0] cam_read_value_i,
    input  logic              cam_search_valid_i,
    input  logic [IDX_W-1:0]  cam_search_index_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [1:0]        rsp_op_o,
    output logic              rsp_hit_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic [1:0]        dbg_state_o
`ifdef CAM_CMD_STATS_EN
    ,
    output logic [15:0]       stat_hits_o,
    output logic [15:0]       stat_misses_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_SEARCH  = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // The WAIT counter runs from CAM_LAT-1 down to 0. CAM_LAT is at most 7.
    localparam logic [2:0] LAT_LOAD = 3'(CAM_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        cnt_q;
    logic              rsp_hit_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              issue;
    logic              cmd_fire;

    // Gate the state decodes with rst_i. This drops enables and handshakes
    // in the same cycle reset is asserted.
    assign issue       = rst_i && (state == ST_ISSUE);
    assign cmd_ready_o = rst_i && (state == ST_IDLE);
    assign rsp_valid_o = rst_i && (state == ST_RESP);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;

    assign cam_read_enable_o   = issue && (op_q == OP_READ);
    assign cam_write_enable_o  = issue && (op_q == OP_WRITE);
    assign cam_search_enable_o = issue && (op_q == OP_SEARCH);
    assign cam_read_index_o    = cam_read_enable_o   ? index_q : '0;
    assign cam_write_index_o   = cam_write_enable_o  ? index_q : '0;
    assign cam_write_data_o    = cam_write_enable_o  ? data_q  : '0;
    assign cam_search_data_o   = cam_search_enable_o ? data_q  : '0;

    assign rsp_op_o    = op_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign dbg_state_o = state;

    // Command FSM: accept, issue one enable, wait for the result, and hold the response.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            index_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op_q       <= cmd_op_i;
                        index_q    <= cmd_index_i;
                        data_q     <= cmd_data_i;
                        rsp_hit_q  <= 1'b0;
                        rsp_data_q <= '0;
                        rsp_err_q  <= (cmd_op_i == OP_ILLEGAL);
                        state      <= (cmd_op_i == OP_ILLEGAL) ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_q == OP_WRITE) begin
                        rsp_hit_q <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt_q <= LAT_LOAD;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (op_q == OP_READ) begin
                            rsp_hit_q  <= cam_read_valid_i;
                            rsp_data_q <= cam_read_valid_i ? cam_read_value_i : '0;
                        end else begin
                            rsp_hit_q  <= cam_search_valid_i;
                            rsp_data_q <= cam_search_valid_i ? DATA_W'(cam_search_index_i) : '0;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CAM_CMD_STATS_EN
    logic search_rsp_fire;
    assign search_rsp_fire = rsp_valid_o && rsp_ready_i && (op_q == OP_SEARCH);

    // Count search hits and misses when their responses are consumed. Each count holds at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else if (search_rsp_fire) begin
            if (rsp_hit_q) begin
                if (stat_hits_o != 16'hFFFF) stat_hits_o <= stat_hits_o + 16'd1;
            end else begin
                if (stat_misses_o != 16'hFFFF) stat_misses_o <= stat_misses_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_cmd_master.sv
// tb_cam_cmd_master: directed and random commands for cam_cmd_master.
// A behavioural CAM model drives the CAM result inputs.
// Expected responses come from an array-based reference of CAM contents.
module tb_cam_cmd_master;
  localparam int IDX_W   = 5;
  localparam int DATA_W  = 32;
  localparam int CAM_LAT = 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i = '0;
  logic [IDX_W-1:0]  cmd_index_i = '0;
  logic [DATA_W-1:0] cmd_data_i = '0;
  logic              cam_read_enable_o;
  logic [IDX_W-1:0]  cam_read_index_o;
  logic              cam_write_enable_o;
  logic [IDX_W-1:0]  cam_write_index_o;
  logic [DATA_W-1:0] cam_write_data_o;
  logic              cam_search_enable_o;
  logic [DATA_W-1:0] cam_search_data_o;
  logic              cam_read_valid_i = 1'b0;
  logic [DATA_W-1:0] cam_read_value_i = '0;
  logic              cam_search_valid_i = 1'b0;
  logic [IDX_W-1:0]  cam_search_index_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [1:0]        rsp_op_o;
  logic              rsp_hit_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic [1:0]        dbg_state_o;
`ifdef CAM_CMD_STATS_EN
  logic [15:0]       stat_hits_o;
  logic [15:0]       stat_misses_o;
  int                exp_hits = 0;
  int                exp_misses = 0;
`endif

  // clock / reset
  always #5 clk_i = ~clk_i;

  cam_cmd_master #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CAM_LAT(CAM_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_index_i(cmd_index_i), .cmd_data_i(cmd_data_i),
    .cam_read_enable_o(cam_read_enable_o), .cam_read_index_o(cam_read_index_o),
    .cam_write_enable_o(cam_write_enable_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .cam_search_enable_o(cam_search_enable_o),
    .cam_search_data_o(cam_search_data_o), .cam_read_valid_i(cam_read_valid_i),
    .cam_read_value_i(cam_read_value_i), .cam_search_valid_i(cam_search_valid_i),
    .cam_search_index_i(cam_search_index_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o), .rsp_hit_o(rsp_hit_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .dbg_state_o(dbg_state_o)
`ifdef CAM_CMD_STATS_EN
    , .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
  );

  // CAM model: memory written by the DUT's write port, results delayed CAM_LAT cycles.
  // Outside a result cycle the result inputs carry random garbage.
  typedef struct packed {
    logic              rd;
    logic              sr;
    logic              hit;
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  idx;
  } cam_res_t;

  logic [DATA_W-1:0] cam_mem [32];
  logic              cam_vld [32] = '{default: 1'b0};
  cam_res_t          pipe [CAM_LAT+1] = '{default: '0};
  cam_res_t          cur;

  always @(negedge clk_i) begin
    cur = '0;
    if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] = cam_write_data_o;
      cam_vld[cam_write_index_o] = 1'b1;
    end
    if (cam_read_enable_o) begin
      cur.rd  = 1'b1;
      cur.hit = cam_vld[cam_read_index_o];
      cur.val = cam_mem[cam_read_index_o];
    end
    if (cam_search_enable_o) begin
      cur.sr = 1'b1;
      for (int i = 31; i >= 0; i--)
        if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
          cur.hit = 1'b1;
          cur.idx = IDX_W'(i);
        end
    end
    for (int i = CAM_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = cur;
    if (pipe[CAM_LAT].rd) begin
      cam_read_valid_i = pipe[CAM_LAT].hit;
      cam_read_value_i = pipe[CAM_LAT].hit ? pipe[CAM_LAT].val : $urandom;
    end else begin
      cam_read_valid_i = 1'($urandom);
      cam_read_value_i = $urandom;
    end
    if (pipe[CAM_LAT].sr) begin
      cam_search_valid_i = pipe[CAM_LAT].hit;
      cam_search_index_i = pipe[CAM_LAT].hit ? pipe[CAM_LAT].idx : IDX_W'($urandom);
    end else begin
      cam_search_valid_i = 1'($urandom);
      cam_search_index_i = IDX_W'($urandom);
    end
  end

  // reference model of intended CAM contents and scoreboard
  logic [DATA_W-1:0] ref_mem [32];
  logic              ref_vld [32] = '{default: 1'b0};
  logic [35:0]       exp_q[$];          // {op, hit, err, data}
  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] pool [4] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h00000001};

  function automatic logic [35:0] ref_response(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                                               input logic [DATA_W-1:0] dat);
    logic              hit;
    logic [DATA_W-1:0] d;
    hit = 1'b0;
    d   = '0;
    case (op)
      2'd0: begin
        hit = ref_vld[idx];
        d   = hit ? ref_mem[idx] : '0;
      end
      2'd1: hit = 1'b1;
      2'd2: begin
        for (int i = 0; i < 32 && !hit; i++)
          if (ref_vld[i] && ref_mem[i] == dat) begin
            hit = 1'b1;
            d   = DATA_W'(i);
          end
      end
      default: ;
    endcase
    return {op, hit, (op == 2'd3), d};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {cmd_ready_o, cam_read_enable_o, cam_read_index_o, cam_write_enable_o,
            cam_write_index_o, cam_write_data_o, cam_search_enable_o, cam_search_data_o,
            rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_err_o, dbg_state_o};
  endfunction

  // driver: one full command/response transaction with `hold` cycles of back-pressure
  task automatic do_op(input logic [1:0] op, input logic [IDX_W-1:0] idx,
                       input logic [DATA_W-1:0] dat, input int hold);
    logic [35:0] exp;
    logic [35:0] got;
    logic [2:0]  exp_en;
    logic [73:0] exp_ports;
    int          lat;
    int          stray;
    int          exp_lat;
    exp = ref_response(op, idx, dat);
    if (op == 2'd1) begin
      ref_mem[idx] = dat;
      ref_vld[idx] = 1'b1;
    end
    exp_q.push_back(exp);
    case (op)
      2'd0: begin exp_en = 3'b100; exp_ports = {idx, 5'd0, 32'd0, 32'd0}; exp_lat = 2 + CAM_LAT; end
      2'd1: begin exp_en = 3'b010; exp_ports = {5'd0, idx, dat, 32'd0};   exp_lat = 2; end
      2'd2: begin exp_en = 3'b001; exp_ports = {5'd0, 5'd0, 32'd0, dat};  exp_lat = 2 + CAM_LAT; end
      default: begin exp_en = 3'b000; exp_ports = '0;                     exp_lat = 1; end
    endcase
    @(negedge clk_i);
    check("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_index_i = idx;
    cmd_data_i  = dat;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'($urandom);
    cmd_index_i = IDX_W'($urandom);
    cmd_data_i  = $urandom;
    check("issue_enables", {cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, exp_en);
    check("issue_ports", {cam_read_index_o, cam_write_index_o, cam_write_data_o, cam_search_data_o},
          exp_ports);
    check("busy_not_ready", cmd_ready_o, 1'b0);
    lat   = 1;
    stray = 0;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (cam_read_enable_o || cam_write_enable_o || cam_search_enable_o) stray++;
    end
    check("no_extra_enable", stray, 0);
    check("rsp_latency", lat, exp_lat);
    got = {rsp_op_o, rsp_hit_o, rsp_err_o, rsp_data_o};
    check("rsp_fields", got, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("rsp_stable", {rsp_valid_o, cmd_ready_o, rsp_op_o, rsp_hit_o, rsp_err_o, rsp_data_o},
            {1'b1, 1'b0, got});
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("post_handshake", {rsp_valid_o, cmd_ready_o}, 2'b01);
`ifdef CAM_CMD_STATS_EN
    if (op == 2'd2) begin
      if (exp[33]) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : 65535;
      else exp_misses = (exp_misses < 65535) ? exp_misses + 1 : 65535;
    end
`endif
  endtask

  task automatic check_stats(input string tag);
`ifdef CAM_CMD_STATS_EN
    check(tag, {stat_hits_o, stat_misses_o}, {16'(exp_hits), 16'(exp_misses)});
`else
    check(tag, dbg_state_o, 2'd0);
`endif
  endtask

  task automatic apply_reset(input int cycles);
    rst_i = 1'b0;
    repeat (cycles) @(negedge clk_i);
    check("reset_outputs", all_outputs(), '0);
`ifdef CAM_CMD_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
    check_stats("reset_stats");
    rst_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_release", {cmd_ready_o, rsp_valid_o}, 2'b10);
  endtask

  initial begin
    logic [1:0] op;
    int         r;
    apply_reset(3);

    // rsp_ready high while idle is ignored
    rsp_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("idle_rsp_ready", {rsp_valid_o, cmd_ready_o}, 2'b01);
    end
    rsp_ready_i = 1'b0;

    // directed: write, read back, search hit, search miss, illegal, read with back-pressure, read miss
    do_op(2'd1, 5'd5, 32'hDEADBEEF, 0);
    do_op(2'd0, 5'd5, 32'h0, 0);
    do_op(2'd2, 5'd0, 32'hDEADBEEF, 0);
    do_op(2'd2, 5'd0, 32'h12345678, 0);
    check_stats("stats_after_searches");
    do_op(2'd3, 5'd7, 32'hFFFFFFFF, 0);
    do_op(2'd0, 5'd5, 32'h0, 4);
    do_op(2'd0, 5'd9, 32'h0, 1);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      do_op(op, IDX_W'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], $urandom_range(0, 3));
    end
    check_stats("stats_after_random");

    // reset while a read is issuing drops the enable immediately
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_index_i = 5'd5;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("rst_issue_enable", cam_read_enable_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("rst_drops_enable", {cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, 3'b000);
    @(negedge clk_i);
    apply_reset(1);

    // reset during WAIT of a search aborts it with no response
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("rst_search_issue", cam_search_enable_o, 1'b1);
    @(negedge clk_i);
    check("in_wait_state", {rsp_valid_o, cmd_ready_o}, 2'b00);
    apply_reset(1);
    repeat (5) begin
      @(negedge clk_i);
      check("no_rsp_after_abort", {rsp_valid_o, cmd_ready_o}, 2'b01);
    end

    // normal operation resumes after the abort
    do_op(2'd2, 5'd0, 32'hDEADBEEF, 2);
    do_op(2'd0, 5'd5, 32'h0, 0);
    check_stats("stats_final");
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cam_cmd_master.md
Name: cam_cmd_master

Overview:
- Initiator side of the CAM port set (read/write/search). Accepts single ops over a valid/ready command channel, drives the CAM's enable/index/data inputs, and samples the CAM's read/search result outputs. Returns one response per command over a valid/ready response channel.
- Sits between the test/control logic and the CAM core. One op in flight at a time.

Parameters:
- IDX_W, 5, CAM index width (32 entries)
- DATA_W, 32, CAM data width
- CAM_LAT, 1, cycles from enable pulse to CAM result valid; legal range 1..7

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; synchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00=read, 01=write, 10=search, 11=illegal
- cmd_index_i  in  IDX_W  read/write index
- cmd_data_i  in  DATA_W  write data / search key
- cam_read_enable_o  out  1  to CAM read_enable_i
- cam_read_index_o  out  IDX_W  to CAM read_index_i
- cam_write_enable_o  out  1  to CAM write_enable_i
- cam_write_index_o  out  IDX_W  to CAM write_index_i
- cam_write_data_o  out  DATA_W  to CAM write_data_i
- cam_search_enable_o  out  1  to CAM search_enable_i
- cam_search_data_o  out  DATA_W  to CAM search_data_i
- cam_read_valid_i  in  1  from CAM read_valid_o
- cam_read_value_i  in  DATA_W  from CAM read_value_o
- cam_search_valid_i  in  1  from CAM search_valid_o (hit)
- cam_search_index_i  in  IDX_W  from CAM search_index_o
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_op_o  out  2  echo of cmd_op
- rsp_hit_o  out  1  read: entry valid; search: match; write: 1; illegal: 0
- rsp_data_o  out  DATA_W  read: value; search: zero-extended index; write/illegal: 0
- rsp_err_o  out  1  1 only for illegal op

Behaviour:
- Reset (rst_i=0 at a clk_i edge): state=IDLE; all outputs 0 except cmd_ready_o, which is 0 during reset and 1 in the first cycle after release. Reset mid-op aborts the op with no response; any enable pulse is dropped the same cycle.
- cmd_ready_o=1 only in IDLE. Op, index and data are registered on acceptance.
- IDLE -> ISSUE on accept of op 00/01/10; IDLE -> RESP on accept of op 11. An illegal op produces no CAM activity.
- ISSUE (exactly 1 cycle):
  - Assert exactly one enable; drive the registered index/data on the matching CAM port.
  - Unused CAM data/index outputs are 0; all enables are 0 outside ISSUE.
  - Write: -> RESP.
  - Read/search: -> WAIT, loading a counter with CAM_LAT-1.
- WAIT: decrement the counter each cycle. In the cycle the counter reads 0 (the ISSUE cycle + CAM_LAT), capture the CAM result into the response registers and go to RESP.
  - Read: hit=cam_read_valid_i; data=cam_read_value_i if hit, else 0.
  - Search: hit=cam_search_valid_i; data={0,cam_search_index_i} if hit, else 0.
- RESP: rsp_valid_o=1 with fields stable until rsp_ready_i=1, then -> IDLE.
  - A new command cannot be accepted in the same cycle as the response handshake; the minimum command spacing is therefore serialising.
- Latency, accept at cycle T:
  - Write: enable at T+1, rsp_valid at T+2.
  - Read/search: enable at T+1, sample at T+1+CAM_LAT, rsp_valid at T+2+CAM_LAT.
  - Illegal: rsp_valid at T+1.
- CAM result inputs are ignored outside the sample cycle.
- rsp_ready_i held high while idle has no effect.

Optional Feature:
- Macro CAM_CMD_STATS_EN.
- Defined: adds ports stat_hits_o and stat_misses_o (out, 16 bits each).
  - Saturating counters, incremented on each search response handshake: hit or miss.
  - Cleared by reset; hold at 16'hFFFF on saturation.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
- Write idx 5 data 32'hDEADBEEF, CAM_LAT=1 -> cam_write_enable_o pulse 1 cycle at T+1 with index 5/data DEADBEEF; rsp at T+2 with op=01, hit=1, data=0, err=0.
- Read idx 5 after that write, CAM model returns read_valid=1/value DEADBEEF at enable+1 -> rsp at T+3 with hit=1, data=32'hDEADBEEF.
- Search key 32'hDEADBEEF (CAM hit at index 5), then key 32'h12345678 (CAM miss) -> responses hit=1, data=5, then hit=0, data=0. With CAM_CMD_STATS_EN: stat_hits_o=1, stat_misses_o=1.
- cmd_op=11 -> no CAM enable ever asserted; rsp at T+1 with err=1, hit=0, data=0.
- rsp_ready_i held low for 4 cycles after rsp_valid -> response fields stable, cmd_ready_o=0 throughout; accept resumes the cycle after the handshake.
- rst_i driven 0 during WAIT of a search -> next cycle all outputs 0 and no response ever issued; cmd_ready_o=1 the first cycle after release.
